// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that lets up to eight byte-stream requesters share one
// 8N1 UART transmitter. It moves one byte at a time into the transmitter. A
// multi-byte message is atomic: once its first byte is accepted, the grant
// stays locked to that requester until its byte flagged `last` is accepted.
//
// Ports
//   clk, reset_n     clock; synchronous active-low reset (shared with the transmitter)
//   req_valid_i      per-requester byte available
//   req_data_i       per-requester byte, requester i at [8i+7:8i]
//   req_last_i       per-requester "byte ends its message"
//   req_ready_o      per-requester accept strobe (combinational, one-hot or zero)
//   tx_start_o       one-cycle launch pulse to the transmitter START
//   tx_data_o        byte to the transmitter DATA, held until the next acceptance
//   tx_busy_i        transmitter BUSY
//   grant_id_o       index of the current / last granted requester
//   locked_o         a message is in progress; only grant_id_o is eligible
//   timeout_err_o    one-cycle pulse when a stalled lock is forcibly released
//
// Optional feature: define UART_ARB_WDOG_EN to build the lock watchdog. A locked
// requester that stays idle for LOCK_TIMEOUT cycles loses its lock. Without the
// macro, timeout_err_o is tied low and a lock lasts until `last` is sent.

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic [2:0]           grant_id_o,
    output logic                 locked_o,
    output logic                 timeout_err_o
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    state_e     state_q;
    logic [2:0] rr_ptr_q;
    logic [2:0] rr_ptr_d;
    logic [2:0] grant_id_q;
    logic       locked_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;

    logic [NUM_REQ-1:0] eligible;
    logic [2:0]         winner;
    logic               found;
    logic               accept;
    logic [7:0]         win_data;
    logic               win_last;

    // While locked, only the granted requester may compete.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (!locked_q || grant_id_q == 3'(i));
        end
    end

    // First eligible index at or after rr_ptr_q, wrapping at NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && eligible[i] && i == (32'(rr_ptr_q) + k) % NUM_REQ) begin
                    winner = 3'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) begin
                win_data = req_data_i[8*i +: 8];
                win_last = req_last_i[i];
            end
        end
    end

    // reset_n gates acceptance so req_ready_o reads zero while reset is held.
    assign accept   = reset_n && (state_q == StIdle) && !tx_busy_i && found;
    assign rr_ptr_d = 3'((32'(winner) + 32'd1) % NUM_REQ);

    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = accept && (winner == 3'(i));
        end
    end

`ifdef UART_ARB_WDOG_EN
    logic [15:0] wdog_cnt_q;
    logic        timeout_err_q;
    logic        grant_valid;
    logic        stall;
    logic [2:0]  grant_next;

    always_comb begin
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                grant_valid = req_valid_i[i];
            end
        end
    end

    assign stall         = (state_q == StIdle) && locked_q && !grant_valid;
    assign grant_next    = 3'((32'(grant_id_q) + 32'd1) % NUM_REQ);
    assign timeout_err_o = timeout_err_q;
`else
    logic unused_lock_timeout;
    assign unused_lock_timeout = ^LOCK_TIMEOUT;
    assign timeout_err_o       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            locked_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            tx_start_q    <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            timeout_err_q <= 1'b0;
            wdog_cnt_q    <= '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_data_q  <= win_data;
                        grant_id_q <= winner;
                        locked_q   <= ~win_last;
                        if (win_last) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                        tx_start_q <= 1'b1;
                        state_q    <= StLaunch;
                    end
`ifdef UART_ARB_WDOG_EN
                    else if (stall) begin
                        if (wdog_cnt_q == LOCK_TIMEOUT - 16'd1) begin
                            locked_q      <= 1'b0;
                            rr_ptr_q      <= grant_next;
                            timeout_err_q <= 1'b1;
                        end else begin
                            wdog_cnt_q <= wdog_cnt_q + 16'd1;
                        end
                    end
`endif
                end
                StLaunch:   state_q <= StWaitBusy;
                StWaitBusy: if (tx_busy_i) state_q <= StWaitDone;
                StWaitDone: if (!tx_busy_i) state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign grant_id_o = grant_id_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: four requesters, a transmitter model whose
// BUSY lasts one 10-bit frame at 4 clocks per bit, directed scenarios plus
// randomized message mixes checked against a message-level round-robin model.

module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int FRAME = 40;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [2:0]        grant_id;
    logic              locked;
    logic              timeout_err;

    logic busy_q = 1'b0;
    logic busy_force = 1'b0;
    int   busy_cnt = 0;

    int total = 0;
    int bad = 0;

    logic [8:0]  pend_q [NREQ][$];
    logic [8:0]  mdl_q [NREQ][$];
    logic [10:0] exp_q [$];
    logic [10:0] got_q [$];
    int          start_cyc_q [$];
    int          cyc = 0;
    int          overlap = 0;
    int          unstable = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .LOCK_TIMEOUT (16'd8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .tx_busy_i     (tx_busy),
        .grant_id_o    (grant_id),
        .locked_o      (locked),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter: BUSY rises the cycle after START and lasts FRAME cycles.
    always @(posedge clk) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            busy_q   <= 1'b1;
            busy_cnt <= FRAME - 1;
        end else if (busy_q) begin
            if (busy_cnt == 0) busy_q <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    assign tx_busy = busy_q | busy_force;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && tx_start) begin
            got_q.push_back({grant_id, tx_data});
            start_cyc_q.push_back(cyc);
            if (busy_q) overlap <= overlap + 1;
        end
        if (reset_n && busy_q && got_q.size() > 0 && tx_data !== got_q[$][7:0])
            unstable <= unstable + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        busy_force = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Presents each requester's queued bytes until all are sent and the link is quiet.
    task automatic run_traffic();
        int   guard;
        int   quiet;
        logic all_empty;
        guard = 0;
        quiet = 0;
        while (quiet < 4 && guard < 20000) begin
            @(negedge clk);
            all_empty = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (pend_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = pend_q[i][0][7:0];
                    req_last[i]        = pend_q[i][0][8];
                    all_empty          = 1'b0;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) void'(pend_q[i].pop_front());
            end
            if (all_empty && !tx_busy && !tx_start) quiet++;
            else quiet = 0;
            guard++;
        end
        req_valid = '0;
        total++;
        if (quiet < 4) begin
            bad++;
            $display("FAIL traffic_timeout: got guard=%0d, required quiet link", guard);
            for (int i = 0; i < NREQ; i++) pend_q[i].delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '1;
        req_last  = '1;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
        total++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
            bad++; $display("FAIL reset_tx: got start=%b data=%h, required 0/00", tx_start, tx_data);
        end
        total++;
        if (grant_id !== 3'd0 || locked !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got grant=%0d locked=%b terr=%b, required 0/0/0",
                     grant_id, locked, timeout_err);
        end
        req_valid = '0;
        req_last  = '0;
        reset_n   = 1'b1;
    endtask

    task automatic test_single_byte();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h0000_A500;
        req_last  = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL single_ready: got %b, required 0010", req_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL single_ready_drop: got %b, required 0000", req_ready);
        end
        total++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            bad++; $display("FAIL single_launch: got start=%b data=%h, required 1/a5", tx_start, tx_data);
        end
        total++;
        if (grant_id !== 3'd1 || locked !== 1'b0) begin
            bad++; $display("FAIL single_grant: got grant=%0d locked=%b, required 1/0", grant_id, locked);
        end
        req_valid = '0;
        run_traffic();
        // rr_ptr is now 2: requester 3 beats requester 0.
        @(negedge clk);
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL single_rr_ptr: got %b, required 1000", req_ready);
        end
        req_valid = '0;
        run_traffic();
    endtask

    task automatic test_simultaneous();
        int base;
        int ov;
        do_reset();
        base = got_q.size();
        ov   = overlap;
        pend_q[0].push_back({1'b1, 8'h11});
        pend_q[2].push_back({1'b1, 8'h22});
        run_traffic();
        total++;
        if (got_q.size() - base != 2) begin
            bad++; $display("FAIL simul_count: got %0d starts, required 2", got_q.size() - base);
        end else begin
            total++;
            if (got_q[base] !== {3'd0, 8'h11} || got_q[base+1] !== {3'd2, 8'h22}) begin
                bad++;
                $display("FAIL simul_order: got %h,%h, required 011,222", got_q[base], got_q[base+1]);
            end
            total++;
            if (start_cyc_q[base+1] - start_cyc_q[base] != FRAME + 3) begin
                bad++;
                $display("FAIL simul_gap: got %0d, required %0d",
                         start_cyc_q[base+1] - start_cyc_q[base], FRAME + 3);
            end
        end
        total++;
        if (overlap != ov) begin
            bad++; $display("FAIL simul_overlap: got %0d starts during busy, required 0", overlap - ov);
        end
    endtask

    task automatic test_locked();
        int base;
        do_reset();
        base = got_q.size();
        pend_q[2].push_back({1'b1, 8'hA0});
        run_traffic();
        pend_q[3].push_back({1'b0, 8'h10});
        pend_q[3].push_back({1'b0, 8'h11});
        pend_q[3].push_back({1'b1, 8'h12});
        pend_q[0].push_back({1'b1, 8'h55});
        run_traffic();
        exp_q.delete();
        exp_q.push_back({3'd2, 8'hA0});
        exp_q.push_back({3'd3, 8'h10});
        exp_q.push_back({3'd3, 8'h11});
        exp_q.push_back({3'd3, 8'h12});
        exp_q.push_back({3'd0, 8'h55});
        total++;
        if (got_q.size() - base != exp_q.size()) begin
            bad++;
            $display("FAIL locked_count: got %0d, required %0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[base+i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL locked_byte%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        // After requester 0's message the pointer sits at 1.
        @(negedge clk);
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL locked_rr_ptr: got %b, required 0010", req_ready);
        end
        req_valid = '0;
        run_traffic();
    endtask

    task automatic test_busy_in_idle();
        do_reset();
        busy_force = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h0000_6600;
        req_last  = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000 || tx_start !== 1'b0) begin
                bad++;
                $display("FAIL busy_idle_block%0d: got ready=%b start=%b, required 0000/0",
                         k, req_ready, tx_start);
            end
            @(negedge clk);
        end
        busy_force = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL busy_idle_release: got %b, required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        run_traffic();
    endtask

    task automatic test_reset_mid();
        int g;
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = 32'h0100_0000;
        req_last  = 4'b0000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL rstmid_accept: got %b, required 1000", req_ready);
        end
        @(negedge clk);
        req_data[31:24] = 8'h02;
        req_last        = 4'b1000;
        g = 0;
        while (!tx_busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (locked !== 1'b1 || tx_busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: got locked=%b busy=%b, required 1/1", locked, tx_busy);
        end
        reset_n         = 1'b0;
        req_valid       = 4'b1001;
        req_data[7:0]   = 8'h77;
        req_last        = 4'b1001;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
            grant_id !== 3'd0 || locked !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_values: got ready=%b start=%b data=%h grant=%0d locked=%b terr=%b, required all 0",
                     req_ready, tx_start, tx_data, grant_id, locked, timeout_err);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rstmid_fresh: got %b, required 0001", req_ready);
        end
        req_valid = '0;
        run_traffic();
    endtask

    task automatic test_random(input int iters);
        int   base;
        int   ov;
        int   un;
        int   ptr;
        int   sel;
        int   nmsg;
        int   len;
        logic done;
        logic last_seen;
        logic [8:0] e;
        for (int it = 0; it < iters; it++) begin
            do_reset();
            base = got_q.size();
            ov   = overlap;
            un   = unstable;
            for (int r = 0; r < NREQ; r++) begin
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        e = {(b == len - 1), 8'($urandom)};
                        pend_q[r].push_back(e);
                        mdl_q[r].push_back(e);
                    end
                end
            end
            // Whole messages are served in round-robin order from requester 0.
            exp_q.delete();
            ptr  = 0;
            done = 1'b0;
            while (!done) begin
                sel = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (sel < 0 && mdl_q[(ptr + k) % NREQ].size() > 0) sel = (ptr + k) % NREQ;
                end
                if (sel < 0) begin
                    done = 1'b1;
                end else begin
                    last_seen = 1'b0;
                    while (!last_seen) begin
                        e = mdl_q[sel].pop_front();
                        exp_q.push_back({3'(sel), e[7:0]});
                        last_seen = e[8];
                    end
                    ptr = (sel + 1) % NREQ;
                end
            end
            run_traffic();
            total++;
            if (got_q.size() - base != exp_q.size()) begin
                bad++;
                $display("FAIL rand%0d_count: got %0d, required %0d", it, got_q.size() - base,
                         exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++;
                    if (got_q[base+i] !== exp_q[i]) begin
                        bad++;
                        $display("FAIL rand%0d_byte%0d: got %h, required %h", it, i, got_q[base+i],
                                 exp_q[i]);
                    end
                    if (i > 0) begin
                        total++;
                        if (start_cyc_q[base+i] - start_cyc_q[base+i-1] != FRAME + 3) begin
                            bad++;
                            $display("FAIL rand%0d_gap%0d: got %0d, required %0d", it, i,
                                     start_cyc_q[base+i] - start_cyc_q[base+i-1], FRAME + 3);
                        end
                    end
                end
            end
            total++;
            if (overlap != ov || unstable != un) begin
                bad++;
                $display("FAIL rand%0d_busy: got overlap=%0d unstable=%0d, required 0/0", it,
                         overlap - ov, unstable - un);
            end
        end
    endtask

`ifdef UART_ARB_WDOG_EN
    task automatic test_watchdog();
        int g;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        req_last  = 4'b0000;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL wdog_accept: got %b, required 0100", req_ready);
        end
        @(negedge clk);
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'h3C;
        req_last        = 4'b0010;
        g = 0;
        while (!tx_busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        while (tx_busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 200) begin
            bad++; $display("FAIL wdog_frame: got %0d cycles, required under 200", g);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (timeout_err !== 1'b0 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL wdog_wait%0d: got terr=%b ready=%b, required 0/0000", k, timeout_err,
                         req_ready);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (timeout_err !== 1'b1 || req_ready !== 4'b0010 || locked !== 1'b0) begin
            bad++;
            $display("FAIL wdog_fire: got terr=%b ready=%b locked=%b, required 1/0010/0",
                     timeout_err, req_ready, locked);
        end
        @(negedge clk);
        #1;
        total++;
        if (grant_id !== 3'd1 || tx_start !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL wdog_regrant: got grant=%0d start=%b terr=%b, required 1/1/0", grant_id,
                     tx_start, timeout_err);
        end
        req_valid = '0;
        run_traffic();
    endtask
`else
    task automatic test_lock_hold();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        req_last  = 4'b0000;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL hold_accept: got %b, required 0100", req_ready);
        end
        @(negedge clk);
        req_valid      = 4'b0010;
        req_data[15:8] = 8'h3C;
        req_last       = 4'b0010;
        repeat (FRAME + 30) @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000 || locked !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL hold_lock: got ready=%b locked=%b terr=%b, required 0000/1/0",
                     req_ready, locked, timeout_err);
        end
        req_valid = '0;
        run_traffic();
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_simultaneous();
        test_locked();
        test_busy_in_idle();
        test_reset_mid();
        test_random(5);
`ifdef UART_ARB_WDOG_EN
        test_watchdog();
`else
        test_lock_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
